// File: rtl/apx_mul_arbiter.sv
// Round-robin arbiter that shares one handshaked floating-point multiplier
// among four requesters, with one operation in flight at a time.
module apx_mul_arbiter #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned DATA_W = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_stb,
    input  logic [N_REQ*DATA_W-1:0]   req_a,
    input  logic [N_REQ*DATA_W-1:0]   req_b,
    output logic [N_REQ-1:0]          req_ack,
    output logic [DATA_W-1:0]         rsp_z,
    output logic [N_REQ-1:0]          rsp_stb,
    input  logic [N_REQ-1:0]          rsp_ack,
    output logic [DATA_W-1:0]         mul_a,
    output logic                      mul_a_stb,
    input  logic                      mul_a_ack,
    output logic [DATA_W-1:0]         mul_b,
    output logic                      mul_b_stb,
    input  logic                      mul_b_ack,
    input  logic [DATA_W-1:0]         mul_z,
    input  logic                      mul_z_stb,
    output logic                      mul_z_ack,
    output logic                      busy,
    output logic [1:0]                grant_id,
    output logic [15:0]               op_count
);

    typedef enum logic [2:0] {
        IDLE,
        SEND_A,
        SEND_B,
        WAIT_Z,
        RESP
    } state_t;

    state_t              state;
    logic [1:0]          last_grant;
    logic [DATA_W-1:0]   cap_a;
    logic [DATA_W-1:0]   cap_b;

    logic [1:0]          next_gnt;
    logic [1:0]          cand;
    logic                found;
    logic [N_REQ-1:0]    gnt_onehot;
    logic [N_REQ-1:0]    cur_onehot;

    assign mul_a = cap_a;
    assign mul_b = cap_b;

    // Search starts one past the last served requester, so a held request
    // cannot win again before every other asserting requester has had a turn.
    always_comb begin
        next_gnt   = last_grant;
        cand       = '0;
        found      = 1'b0;
        gnt_onehot = '0;
        cur_onehot = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = last_grant + 2'(k);
            if (!found && req_stb[cand]) begin
                next_gnt = cand;
                found    = 1'b1;
            end
        end
        gnt_onehot[next_gnt] = 1'b1;
        cur_onehot[grant_id] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            last_grant <= 2'd3;
            grant_id   <= '0;
            op_count   <= '0;
            rsp_z      <= '0;
            req_ack    <= '0;
            rsp_stb    <= '0;
            mul_a_stb  <= 1'b0;
            mul_b_stb  <= 1'b0;
            mul_z_ack  <= 1'b0;
            busy       <= 1'b0;
            cap_a      <= '0;
            cap_b      <= '0;
        end else begin
            req_ack <= '0;
            case (state)
                IDLE: begin
                    if (|req_stb) begin
                        grant_id  <= next_gnt;
                        req_ack   <= gnt_onehot;
                        cap_a     <= req_a[next_gnt*DATA_W +: DATA_W];
                        cap_b     <= req_b[next_gnt*DATA_W +: DATA_W];
                        mul_a_stb <= 1'b1;
                        busy      <= 1'b1;
                        state     <= SEND_A;
                    end
                end
                SEND_A: begin
                    if (mul_a_stb && mul_a_ack) begin
                        mul_a_stb <= 1'b0;
                        mul_b_stb <= 1'b1;
                        state     <= SEND_B;
                    end
                end
                SEND_B: begin
                    if (mul_b_stb && mul_b_ack) begin
                        mul_b_stb <= 1'b0;
                        mul_z_ack <= 1'b1;
                        state     <= WAIT_Z;
                    end
                end
                WAIT_Z: begin
                    if (mul_z_stb && mul_z_ack) begin
                        rsp_z     <= mul_z;
                        mul_z_ack <= 1'b0;
                        rsp_stb   <= cur_onehot;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ack[grant_id]) begin
                        rsp_stb    <= '0;
                        op_count   <= op_count + 16'd1;
                        last_grant <= grant_id;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
